gpio_frame_tx: RTL and testbench
================================

// Module: gpio_frame_tx
// PURPOSE
//   Return-path transmitter for filtered price samples: buffers 8-bit averaged values from the
//   moving-average stage and sends each one to the Raspberry Pi over the 8-bit GPIO bus.
//   Each sample goes out as a 3-byte frame using a four-phase req/ack handshake.
//   It is the outbound counterpart of the inbound GPIO sample path; the RPi side is the ack source.
// PARAMETERS
//   FIFO_DEPTH   8        sample buffer depth; power of two, >= 2
//   SYNC_BYTE    8'hA5    frame header byte
//   TIMEOUT_CYC  100000   max cycles waiting on any ack edge before the frame is aborted
//   TO_W         17       timeout counter width; must hold TIMEOUT_CYC
// PORTS
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset
//   in_valid       in   1  averaged sample present on in_data
//   in_data        in   8  averaged sample
//   in_ready       out  1  FIFO not full; a write occurs iff in_valid && in_ready
//   rpi_gpio_tx_o  out  8  frame byte driven to the RPi
//   rpi_tx_req_o   out  1  handshake request to the RPi
//   rpi_tx_ack     in   1  handshake ack from the RPi; asynchronous to clk
//   busy           out  1  state != IDLE
//   timeout_err    out  1  one-cycle pulse when a frame is aborted
//   drop_cnt       out  8  samples rejected while full; saturates at 255
// BEHAVIOUR
// - Reset is asynchronous, active-low: all outputs 0, FIFO empty, state IDLE, ack synchronizer 0.
//   Reset mid-frame discards the frame and all buffered samples.
// - ack_s = rpi_tx_ack through a 2-FF synchronizer; only ack_s is used internally.
// - FIFO: in_ready = !full, from registered count only.
//   A write while full is not accepted, even if a pop happens in the same cycle.
//   Each in_valid && !in_ready cycle increments drop_cnt, saturating at 255.
//   Pointers wrap mod FIFO_DEPTH. Order is preserved.
// - Frame = {SYNC_BYTE, DATA, CHK}, where CHK = SYNC_BYTE ^ DATA. Bytes are sent in that order.
// - FSM states: IDLE, SETUP, WAIT_HI, WAIT_LO, ABORT.
//   IDLE: when FIFO not empty and ack_s==0: pop, latch DATA, byte_idx=0,
//     rpi_gpio_tx_o<=SYNC_BYTE, go to SETUP. A stale ack_s==1 blocks frame start.
//   SETUP: rpi_tx_req_o<=1, clear timeout counter, go to WAIT_HI.
//     Data is stable at least 1 cycle before req rises.
//   WAIT_HI: when ack_s==1: rpi_tx_req_o<=0, clear counter, go to WAIT_LO.
//   WAIT_LO: when ack_s==0:
//     if byte_idx==2: rpi_gpio_tx_o<=0, go to IDLE;
//     else byte_idx++, drive the next byte, go to SETUP.
//   rpi_gpio_tx_o holds constant from SETUP entry until WAIT_LO exit.
//   Timeout: in WAIT_HI or WAIT_LO, when the counter reaches TIMEOUT_CYC:
//     rpi_tx_req_o<=0, rpi_gpio_tx_o<=0, pulse timeout_err, go to ABORT.
//     The frame is lost; it is not retried.
//   ABORT: wait for ack_s==0, with no timeout, then go to IDLE.
// - Latency, idle and empty with ack low: write at edge E0; SYNC_BYTE driven at E1; req rises at E2.
//   Each byte then needs 2 sync edges per ack transition, plus SETUP.
// - A simultaneous FIFO write and pop in the same cycle (when not full) is legal and keeps count.
// STRUCTURE
// - Package gpio_tx_pkg: state enum (IDLE..ABORT), FRAME_LEN=3, BYTE_IDX_W=2,
//   default SYNC_BYTE, CHK function (xor).
// - Sub-module gpio_sync_fifo (8-bit wide, FIFO_DEPTH deep; push/pop/full/empty/count).
//   FSM, synchronizer, timeout counter and drop counter stay in gpio_frame_tx.
// TESTING (bench RPi model acks N cycles after each req edge)
// 1. One sample 0x3C, ack delay 4 -> bytes A5,3C,99 in order; req 0->1->0 per byte;
//    busy low after third ack falls; timeout_err never pulses.
// 2. 10 back-to-back samples 0x01..0x0A, ack held low until cycle 200 -> in_ready low after
//    8 accepts (first popped into frame), drop_cnt=1 or 2 per pop timing (check exact: 1);
//    release -> 9 frames in order.
// 3. RPi never acks -> TIMEOUT_CYC cycles after req rises: req=0, tx=0, one-cycle timeout_err;
//    ack restored -> next queued sample framed normally.
// 4. rst_n low during WAIT_LO of byte 2 -> req, tx, busy, drop_cnt 0 immediately;
//    after release in_ready=1, no frame emitted.
// 5. rpi_tx_ack held 1 before a sample arrives -> no SYNC_BYTE/req until ack low + 2 cycles.
// 6. FIFO_DEPTH=2, ack stalled, 300 writes -> drop_cnt saturates at 255, never wraps.

Source files
------------

// File: rtl/gpio_tx_pkg.sv
// Shared types and helpers for the GPIO return-path frame transmitter.
package gpio_tx_pkg;

   localparam int         FRAME_LEN         = 3;
   localparam int         BYTE_IDX_W        = 2;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      ABORT   = 3'd4
   } tx_state_t;

   // Frame check byte: header xor payload.
   function automatic logic [7:0] chk_byte(input logic [7:0] sync_b, input logic [7:0] data_b);
      return sync_b ^ data_b;
   endfunction

endpackage

// File: rtl/gpio_sync_fifo.sv
// Single-clock sample buffer, 8 bits wide, DEPTH entries (power of two).
// Ports:
//   clk, rst_n      clock, async active-low reset (empties the buffer)
//   push, wr_data   write request and data; ignored while full
//   pop, rd_data    read request; rd_data shows the head entry
//   full, empty     derived from the registered occupancy count
module gpio_sync_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wr_data,
   input  logic       pop,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/gpio_frame_tx.sv
// Return-path transmitter: buffers averaged samples and sends each as a
// {SYNC, DATA, SYNC^DATA} frame over the GPIO bus with a four-phase req/ack.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   in_valid/in_data/in_ready   sample input, write iff in_valid && in_ready
//   rpi_gpio_tx_o    frame byte to the RPi
//   rpi_tx_req_o     handshake request
//   rpi_tx_ack       handshake ack from the RPi (asynchronous)
//   busy             FSM not idle
//   timeout_err      one-cycle pulse when a frame is aborted
//   drop_cnt         samples rejected while full, saturating
//
// state   | meaning
// IDLE    | waiting for a buffered sample and ack low
// SETUP   | byte on the bus, raise req next edge
// WAIT_HI | req high, waiting for ack high
// WAIT_LO | req low, waiting for ack low
// ABORT   | timed out, waiting for ack low before idling
module gpio_frame_tx
   import gpio_tx_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 8,
   parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYC = 100000,
   parameter int         TO_W        = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] rpi_gpio_tx_o,
   output logic       rpi_tx_req_o,
   input  logic       rpi_tx_ack,
   output logic       busy,
   output logic       timeout_err,
   output logic [7:0] drop_cnt
);

   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

   tx_state_t             state_q, state_n;
   logic [7:0]            data_q, data_n;
   logic [BYTE_IDX_W-1:0] idx_q, idx_n;
   logic [7:0]            tx_q, tx_n;
   logic                  req_q, req_n;
   logic [TO_W-1:0]       to_q, to_n;
   logic                  terr_n;
   logic                  ack_m, ack_s;
   logic                  fifo_full, fifo_empty, fifo_pop;
   logic [7:0]            fifo_data;

   gpio_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid && in_ready),
      .wr_data (in_data),
      .pop     (fifo_pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign in_ready      = !fifo_full;
   assign busy          = (state_q != IDLE);
   assign rpi_gpio_tx_o = tx_q;
   assign rpi_tx_req_o  = req_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= rpi_tx_ack;
         ack_s <= ack_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (in_valid && !in_ready && drop_cnt != 8'hFF) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         idx_q       <= '0;
         tx_q        <= '0;
         req_q       <= 1'b0;
         to_q        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_n;
         data_q      <= data_n;
         idx_q       <= idx_n;
         tx_q        <= tx_n;
         req_q       <= req_n;
         to_q        <= to_n;
         timeout_err <= terr_n;
      end
   end

   // Timeout is a down-counter loaded on each handshake phase; reaching zero
   // while still waiting aborts the frame TIMEOUT_CYC edges after the load.
   always_comb begin
      state_n  = state_q;
      data_n   = data_q;
      idx_n    = idx_q;
      tx_n     = tx_q;
      req_n    = req_q;
      to_n     = to_q;
      terr_n   = 1'b0;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !ack_s) begin
               fifo_pop = 1'b1;
               data_n   = fifo_data;
               idx_n    = '0;
               tx_n     = SYNC_BYTE;
               state_n  = SETUP;
            end
         end
         SETUP: begin
            req_n   = 1'b1;
            to_n    = TO_LOAD;
            state_n = WAIT_HI;
         end
         WAIT_HI: begin
            if (ack_s) begin
               req_n   = 1'b0;
               to_n    = TO_LOAD;
               state_n = WAIT_LO;
            end else if (to_q == '0) begin
               req_n   = 1'b0;
               tx_n    = '0;
               terr_n  = 1'b1;
               state_n = ABORT;
            end else begin
               to_n = to_q - 1'b1;
            end
         end
         WAIT_LO: begin
            if (!ack_s) begin
               if (idx_q == BYTE_IDX_W'(FRAME_LEN - 1)) begin
                  tx_n    = '0;
                  state_n = IDLE;
               end else begin
                  idx_n   = idx_q + 1'b1;
                  tx_n    = (idx_q == '0) ? data_q : chk_byte(SYNC_BYTE, data_q);
                  state_n = SETUP;
               end
            end else if (to_q == '0) begin
               tx_n    = '0;
               terr_n  = 1'b1;
               state_n = ABORT;
            end else begin
               to_n = to_q - 1'b1;
            end
         end
         ABORT: begin
            if (!ack_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gpio_frame_tx.sv
module tb_gpio_frame_tx;

   localparam int TO_CYC = 400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready;
   logic [7:0] rpi_gpio_tx_o;
   logic       rpi_tx_req_o;
   logic       rpi_tx_ack = 1'b0;
   logic       busy;
   logic       timeout_err;
   logic [7:0] drop_cnt;

   logic       in_valid2 = 1'b0;
   logic [7:0] in_data2 = '0;
   logic       ack2 = 1'b0;
   logic       in_ready2, req2, busy2, terr2;
   logic [7:0] tx2, drop2;

   always #5 clk = ~clk;

   gpio_frame_tx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TO_CYC), .TO_W(17)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rpi_gpio_tx_o(rpi_gpio_tx_o), .rpi_tx_req_o(rpi_tx_req_o),
      .rpi_tx_ack(rpi_tx_ack), .busy(busy), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
   );

   gpio_frame_tx #(.FIFO_DEPTH(2), .TIMEOUT_CYC(TO_CYC), .TO_W(17)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
      .in_ready(in_ready2), .rpi_gpio_tx_o(tx2), .rpi_tx_req_o(req2),
      .rpi_tx_ack(ack2), .busy(busy2), .timeout_err(terr2), .drop_cnt(drop2)
   );

   typedef struct {
      logic [7:0] data;
      int         dly;
      logic [7:0] exp_chk;
   } vec_t;

   vec_t       vecs [5];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] cap [$];
   logic       req_prev = 1'b0;
   int         to_seen = 0;
   bit         ack_en = 1'b0;
   logic       ack_force = 1'b0;
   int         ack_dly = 4;
   int         dly = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample DUT at the falling edge, then update the RPi ack model.
   task automatic tick();
      @(negedge clk);
      if (rpi_tx_req_o && !req_prev) cap.push_back(rpi_gpio_tx_o);
      req_prev = rpi_tx_req_o;
      if (timeout_err) to_seen++;
      if (ack_en) begin
         if (rpi_tx_ack != rpi_tx_req_o) begin
            dly++;
            if (dly >= ack_dly) begin
               rpi_tx_ack = rpi_tx_req_o;
               dly = 0;
            end
         end else begin
            dly = 0;
         end
      end else begin
         rpi_tx_ack = ack_force;
         dly = 0;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int nbytes, input int max_cyc, input string name);
      int k = 0;
      while (!(cap.size() >= nbytes && !busy) && k < max_cyc) begin
         tick();
         k++;
      end
      if (k >= max_cyc) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: wait expired, got %0d bytes busy=%0b", name, cap.size(), busy);
      end
   endtask

   task automatic chk_frame(input string name, input logic [7:0] d, input logic [7:0] c);
      chk({name, "_n"}, cap.size(), 3);
      if (cap.size() >= 3) begin
         chk({name, "_b0"}, cap[0], 8'hA5);
         chk({name, "_b1"}, cap[1], d);
         chk({name, "_b2"}, cap[2], c);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h3C, 4, 8'h99};
      vecs[1] = '{8'h00, 1, 8'hA5};
      vecs[2] = '{8'hFF, 2, 8'h5A};
      vecs[3] = '{8'hA5, 3, 8'h00};
      vecs[4] = '{8'h5A, 6, 8'hFF};

      // Reset state
      repeat (3) tick();
      chk("rst_req", rpi_tx_req_o, 0);
      chk("rst_tx", rpi_gpio_tx_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_drop", drop_cnt, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", in_ready, 1);

      // Latency: write at E0, sync byte at E1, req at E2
      ack_en = 1'b1;
      ack_dly = 4;
      wr(8'h3C);
      chk("lat_e0_tx", rpi_gpio_tx_o, 0);
      tick();
      chk("lat_e1_tx", rpi_gpio_tx_o, 8'hA5);
      chk("lat_e1_req", rpi_tx_req_o, 0);
      chk("lat_e1_busy", busy, 1);
      tick();
      chk("lat_e2_req", rpi_tx_req_o, 1);
      wait_done(3, 200, "lat");
      chk_frame("lat", 8'h3C, 8'h99);
      chk("lat_req_low", rpi_tx_req_o, 0);

      // Single-sample frames with varying ack delays
      for (int i = 0; i < 5; i++) begin
         cap.delete();
         ack_dly = vecs[i].dly;
         wr(vecs[i].data);
         wait_done(3, 300, "vec");
         chk_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_chk);
      end
      chk("vec_no_timeout", to_seen, 0);

      // Back-to-back writes with ack stalled: 9 accepted, 1 dropped
      cap.delete();
      ack_en = 1'b0;
      ack_force = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("b2b_ready%0d", i), in_ready, (i < 9) ? 1 : 0);
         in_valid = 1'b1;
         in_data  = 8'(i + 1);
         tick();
      end
      in_valid = 1'b0;
      chk("b2b_drop", drop_cnt, 1);
      repeat (150) tick();
      ack_en = 1'b1;
      ack_dly = 2;
      wait_done(27, 3000, "b2b");
      chk("b2b_n", cap.size(), 27);
      for (int f = 0; f < 9; f++) begin
         if (cap.size() >= 3 * f + 3) begin
            chk($sformatf("b2b_f%0d_sync", f), cap[3*f], 8'hA5);
            chk($sformatf("b2b_f%0d_data", f), cap[3*f+1], 8'(f + 1));
            chk($sformatf("b2b_f%0d_chk", f), cap[3*f+2], 8'hA5 ^ 8'(f + 1));
         end
      end
      chk("b2b_no_timeout", to_seen, 0);

      // Timeout: RPi never acks
      cap.delete();
      ack_en = 1'b0;
      ack_force = 1'b0;
      wr(8'h77);
      wr(8'h42);
      begin
         int k = 0;
         while (!rpi_tx_req_o && k < 20) begin tick(); k++; end
         chk("to_req_rise", rpi_tx_req_o, 1);
         k = 0;
         while (rpi_tx_req_o && k < TO_CYC + 50) begin tick(); k++; end
         chk("to_len", k, TO_CYC);
      end
      chk("to_tx", rpi_gpio_tx_o, 0);
      chk("to_pulse", timeout_err, 1);
      tick();
      chk("to_pulse_end", timeout_err, 0);
      chk("to_count", to_seen, 1);
      cap.delete();
      ack_en = 1'b1;
      ack_dly = 3;
      wait_done(3, 300, "to_next");
      chk_frame("to_next", 8'h42, 8'hE7);
      chk("to_count_after", to_seen, 1);

      // Reset during WAIT_LO of the third byte
      cap.delete();
      ack_dly = 8;
      wr(8'h3C);
      wr(8'h10);
      wr(8'h20);
      begin
         int k = 0;
         while (cap.size() < 3 && k < 300) begin tick(); k++; end
         k = 0;
         while (rpi_tx_req_o && k < 50) begin tick(); k++; end
      end
      chk("rstf_before_busy", busy, 1);
      chk("rstf_before_drop", drop_cnt, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rstf_req", rpi_tx_req_o, 0);
      chk("rstf_tx", rpi_gpio_tx_o, 0);
      chk("rstf_busy", busy, 0);
      chk("rstf_drop", drop_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rstf_ready", in_ready, 1);
      repeat (60) tick();
      chk("rstf_no_frame", cap.size(), 3);
      chk("rstf_idle", busy, 0);

      // Stale ack high blocks frame start until ack low + 2 syncs
      cap.delete();
      ack_en = 1'b0;
      ack_force = 1'b1;
      repeat (5) tick();
      wr(8'h11);
      repeat (10) tick();
      chk("stale_req", rpi_tx_req_o, 0);
      chk("stale_tx", rpi_gpio_tx_o, 0);
      chk("stale_busy", busy, 0);
      ack_force = 1'b0;
      tick();
      tick();
      chk("stale_ea_tx", rpi_gpio_tx_o, 0);
      tick();
      chk("stale_ea1_tx", rpi_gpio_tx_o, 0);
      tick();
      chk("stale_ea2_tx", rpi_gpio_tx_o, 8'hA5);
      chk("stale_ea2_req", rpi_tx_req_o, 0);
      tick();
      chk("stale_ea3_req", rpi_tx_req_o, 1);
      ack_en = 1'b1;
      ack_dly = 2;
      wait_done(3, 300, "stale");
      chk_frame("stale", 8'h11, 8'hB4);

      // Depth-2 instance, stalled ack, 300 writes: drop counter saturates
      in_valid2 = 1'b1;
      for (int i = 0; i < 300; i++) begin
         in_data2 = 8'(i);
         tick();
         if (i == 99) chk("sat_mid", drop2, 97);
      end
      in_valid2 = 1'b0;
      chk("sat_end", drop2, 255);
      chk("sat_ready", in_ready2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
